// File: rtl/buzz_arbiter_pkg.sv
// rtl/buzz_arbiter_pkg.sv - shared types and constants for the buzzer arbiter
package buzz_arbiter_pkg;

  localparam int NUM_PLAYERS = 4;
  localparam int DEB_CYC_DEF = 3;
  // count from the countdown stage is stale for this many ARMED cycles
  localparam int ARM_BLANK   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  function automatic logic [1:0] prio_idx(input logic [NUM_PLAYERS-1:0] ev);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (ev[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/buzz_arbiter_key_debounce.sv
// rtl/buzz_arbiter_key_debounce.sv - per-key synchronizer, debouncer and press-pulse generator
module key_debounce
  import buzz_arbiter_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk_count,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic [3:0] cnt;

  // presets of 1 mean "released", so no press can follow reset release
  always_ff @(posedge clk_count or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= 4'd0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= 4'd0;
      end else if (cnt == DEB_LAST) begin
        level <= sync2;
        cnt   <= 4'd0;
        press <= level;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/buzz_arbiter.sv
// rtl/buzz_arbiter.sv - 4-player buzzer arbiter; FOUL_DETECT_EN enables early-press fouls
module buzz_arbiter
  import buzz_arbiter_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic                   clk_count,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clr,
  input  logic [NUM_PLAYERS-1:0] key_n,
  input  logic                   count,
  output logic                   zd,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic [1:0]             winner_id,
  output logic                   valid,
  output logic                   timeout,
  output logic [NUM_PLAYERS-1:0] foul
);

  state_t                 state, state_d;
  logic [NUM_PLAYERS-1:0] press;
  logic [NUM_PLAYERS-1:0] elig;
  logic [NUM_PLAYERS-1:0] winner_d;
  logic [1:0]             winner_id_d;
  logic                   valid_d;
  logic                   timeout_d;
  logic [1:0]             arm_cnt;
  logic                   count_ok;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_key
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk_count (clk_count),
      .rst_n     (rst_n),
      .key_n     (key_n[g]),
      .press     (press[g])
    );
  end

`ifdef FOUL_DETECT_EN
  logic [NUM_PLAYERS-1:0] foul_q;

  always_ff @(posedge clk_count or negedge rst_n) begin
    if (!rst_n)                foul_q <= '0;
    else if (clr)              foul_q <= '0;
    else if (state == ST_IDLE) foul_q <= foul_q | press;
  end

  assign foul = foul_q;
  assign elig = press & ~foul_q;
`else
  assign foul = '0;
  assign elig = press;
`endif

  assign count_ok = (arm_cnt == 2'(ARM_BLANK));

  always_comb begin
    state_d     = state;
    winner_d    = winner;
    winner_id_d = winner_id;
    valid_d     = valid;
    timeout_d   = timeout;
    if (clr) begin
      state_d     = ST_IDLE;
      winner_d    = '0;
      winner_id_d = 2'd0;
      valid_d     = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          // a press on the same edge as a qualified expiry still wins
          if (|elig) begin
            state_d              = ST_LOCKED;
            winner_id_d          = prio_idx(elig);
            winner_d             = '0;
            winner_d[winner_id_d] = 1'b1;
            valid_d              = 1'b1;
          end else if (count && count_ok) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_count or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      zd        <= 1'b1;
      winner    <= '0;
      winner_id <= 2'd0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      arm_cnt   <= 2'd0;
    end else begin
      state     <= state_d;
      zd        <= (state_d != ST_ARMED);
      winner    <= winner_d;
      winner_id <= winner_id_d;
      valid     <= valid_d;
      timeout   <= timeout_d;
      if (state != ST_ARMED)  arm_cnt <= 2'd0;
      else if (!count_ok)     arm_cnt <= arm_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_buzz_arbiter.sv
// tb/tb_buzz_arbiter.sv - self-checking bench for buzz_arbiter with a behavioural reference model
module tb_buzz_arbiter;

  localparam int DEB = 3;
`ifdef FOUL_DETECT_EN
  localparam bit FOUL_EN = 1'b1;
`else
  localparam bit FOUL_EN = 1'b0;
`endif

  logic       clk_count = 1'b0;
  logic       rst_n, start, clr, count;
  logic [3:0] key_n;
  logic       zd, valid, timeout;
  logic [3:0] winner, foul;
  logic [1:0] winner_id;

  int n_tests;
  int n_fail;

  buzz_arbiter #(.DEB_CYC(DEB)) dut (
    .clk_count (clk_count),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .key_n     (key_n),
    .count     (count),
    .zd        (zd),
    .winner    (winner),
    .winner_id (winner_id),
    .valid     (valid),
    .timeout   (timeout),
    .foul      (foul)
  );

  always #5 clk_count = ~clk_count;

  // reference model: mode 0 idle, 1 armed, 2 locked, 3 expired
  int          m_mode, m_age;
  logic [1:0]  m_id;
  logic        m_valid, m_tout, m_samp, m_flip, m_found;
  logic [3:0]  m_foul, m_press, m_ev, m_elig, m_np, m_sy1, m_sy2, m_lvl;
  logic [14:0] m_hist [4];

  always @(posedge clk_count or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_id = 2'd0; m_valid = 1'b0; m_tout = 1'b0;
      m_foul = 4'd0; m_press = 4'd0; m_sy1 = 4'hF; m_sy2 = 4'hF; m_lvl = 4'hF;
      for (int i = 0; i < 4; i++) m_hist[i] = '1;
    end else begin
      m_ev   = m_press;
      m_elig = FOUL_EN ? (m_ev & ~m_foul) : m_ev;
      if (clr) begin
        m_mode = 0; m_id = 2'd0; m_valid = 1'b0; m_tout = 1'b0; m_foul = 4'd0;
      end else if (m_mode == 0) begin
        if (FOUL_EN) m_foul = m_foul | m_ev;
        if (start) begin m_mode = 1; m_age = 0; end
      end else if (m_mode == 1) begin
        if (m_elig != 4'd0) begin
          m_found = 1'b0;
          for (int i = 0; i < 4; i++)
            if (m_elig[i] && !m_found) begin m_id = 2'(i); m_found = 1'b1; end
          m_valid = 1'b1; m_mode = 2;
        end else if (count && m_age >= 2) begin
          m_tout = 1'b1; m_mode = 3;
        end else begin
          m_age = m_age + 1;
        end
      end
      // a key level flips once its last DEB synchronized samples all disagree with it
      for (int i = 0; i < 4; i++) begin
        m_samp   = m_sy2[i];
        m_sy2[i] = m_sy1[i];
        m_sy1[i] = key_n[i];
        m_hist[i] = {m_hist[i][13:0], m_samp};
        m_flip = 1'b1;
        for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_lvl[i]) m_flip = 1'b0;
        m_np[i] = m_flip && m_lvl[i];
        if (m_flip) m_lvl[i] = ~m_lvl[i];
      end
      m_press = m_np;
    end
  end

  task automatic cmp_model();
    logic [12:0] act, exp;
    act = {zd, winner, winner_id, valid, timeout, foul};
    exp = {(m_mode != 1), (m_valid ? (4'd1 << m_id) : 4'd0), m_id, m_valid, m_tout,
           (FOUL_EN ? m_foul : 4'd0)};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_count);
      cmp_model();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_and_arm();
    clr = 1'b1; step(1); clr = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; count = 1'b0; key_n = 4'hF;
    step(3);
    chk("reset_zd", zd, 1); chk("reset_winner", winner, 0); chk("reset_id", winner_id, 0);
    chk("reset_valid", valid, 0); chk("reset_timeout", timeout, 0); chk("reset_foul", foul, 0);
    rst_n = 1'b1; step(2);

    // key 2 press ten cycles after arming; latency is 2 sync + DEB + 1 FSM edges
    start = 1'b1; step(1); start = 1'b0; step(10);
    key_n = 4'b1011; step(5);
    chk("a_not_yet", valid, 0);
    step(1);
    chk("a_winner", winner, 4'b0100); chk("a_id", winner_id, 2);
    chk("a_valid", valid, 1); chk("a_zd", zd, 1);
    step(3); key_n = 4'hF; step(8);

    // simultaneous presses on keys 1 and 3
    clear_and_arm(); step(3);
    key_n = 4'b0101; step(8);
    chk("b_winner", winner, 4'b0010); chk("b_id", winner_id, 1);
    key_n = 4'hF; step(8);

    // count during the two blanking cycles is ignored, later expiry times out
    clear_and_arm();
    count = 1'b1; step(2);
    chk("c_blank_tout", timeout, 0); chk("c_blank_zd", zd, 0);
    count = 1'b0; step(13);
    count = 1'b1; step(1); count = 1'b0;
    chk("c_timeout", timeout, 1); chk("c_valid", valid, 0); chk("c_zd", zd, 1);
    start = 1'b1; step(2); start = 1'b0;
    chk("c_hold", timeout, 1);

    // glitch shorter than DEB is rejected
    clear_and_arm(); step(4);
    key_n = 4'b1110; step(DEB - 1); key_n = 4'hF; step(8);
    chk("d_glitch_valid", valid, 0); chk("d_glitch_zd", zd, 0);

    // press and qualified count on the same edge: press wins
    key_n = 4'b0111; step(5);
    count = 1'b1; step(1); count = 1'b0;
    chk("e_valid", valid, 1); chk("e_winner", winner, 4'b1000); chk("e_tout", timeout, 0);

    // clr beats start on the same edge
    step(2); clr = 1'b1; start = 1'b1; step(1); clr = 1'b0; start = 1'b0;
    chk("f_valid", valid, 0); chk("f_winner", winner, 0); chk("f_id", winner_id, 0);
    chk("f_zd", zd, 1); chk("f_tout", timeout, 0);
    key_n = 4'hF; step(8);
    chk("f_idle", zd, 1);

    // press in IDLE does not arm anything
    key_n = 4'b1101; step(8);
    chk("g_valid", valid, 0); chk("g_zd", zd, 1);
    if (FOUL_EN) chk("g_foul", foul, 4'b0010);
    key_n = 4'hF; step(6);

    // reset mid-round discards the latched winner
    clear_and_arm(); step(3);
    key_n = 4'b1101; step(6);
    chk("h_locked", valid, 1);
    rst_n = 1'b0; step(1);
    chk("h_rst_valid", valid, 0); chk("h_rst_winner", winner, 0); chk("h_rst_zd", zd, 1);
    key_n = 4'hF; step(1); rst_n = 1'b1; step(8);
    chk("h_after_valid", valid, 0); chk("h_after_zd", zd, 1);

`ifdef FOUL_DETECT_EN
    clr = 1'b1; step(1); clr = 1'b0;
    key_n = 4'b1110; step(7); key_n = 4'hF; step(6);
    chk("i_foul", foul, 4'b0001);
    start = 1'b1; step(1); start = 1'b0; step(3);
    key_n = 4'b1110; step(7); key_n = 4'hF; step(6);
    chk("i_fouled_ignored", valid, 0);
    key_n = 4'b0111; step(7);
    chk("i_winner", winner, 4'b1000); chk("i_foul_kept", foul, 4'b0001);
    key_n = 4'hF; step(4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
